fwd_hazard_ctrl: RTL and testbench
==================================

// Module: fwd_hazard_ctrl
// PURPOSE
//  Forwarding/hazard controller for the 5-stage MIPS pipeline.
//  Shadows the destination register and control bits of the EX, MEM and WB stages.
//  Drives the 2-bit selects of the two 3:1 ALU-operand forwarding muxes.
//  Raises a load-use stall to the IF/ID stage and keeps a saturating stall counter.
// PARAMETERS
//  REG_W  5   register-specifier width (one of 32 GPRs; $zero = 0)
//  CNT_W  16  width of stall-statistics counter
// PORTS
//  Clk          in   1      pipeline clock, rising edge
//  Rst_n        in   1      asynchronous, active-low reset
//  ID_Rs        in   REG_W  rs of instruction in decode
//  ID_Rt        in   REG_W  rt of instruction in decode
//  ID_UsesRt    in   1      decode instruction reads rt as a source (R-type, beq/bne, sw)
//  ID_Dst       in   REG_W  dest reg from the 5-bit dst mux (rt/rd/31)
//  ID_RegWrite  in   1      decode instruction writes the register file
//  ID_MemRead   in   1      decode instruction is a load
//  Flush        in   1      branch/jump taken in ID: squash decode instruction
//  ForwardA     out  2      ALU operand A mux select for EX-stage rs
//  ForwardB     out  2      ALU operand B mux select for EX-stage rt
//  Stall        out  1      hold PC and IF/ID this cycle; bubble into EX
//  StallCount   out  CNT_W  number of stall cycles since reset, saturating
// BEHAVIOUR
//  Forward encoding (matches the 3:1 mux):
//   - 00 = register file
//   - 01 = EX/MEM result
//   - 10 = MEM/WB result
//   - 11 is never driven
//  Shadow registers (all async-cleared to 0 by Rst_n):
//   - EX:  {Rs, Rt, Dst, RegWrite, MemRead}
//   - MEM: {Dst, RegWrite, MemRead}
//   - WB:  {Dst, RegWrite}
//  Each rising Clk:
//   - WB <= MEM, MEM <= EX (always advance; no back-pressure from downstream).
//   - If Stall or Flush: EX <= bubble (all fields 0).
//   - Otherwise: EX <= ID inputs.
//  Stall (combinational from EX shadow + ID inputs): asserted when all hold:
//   - EX.MemRead and EX.Dst != 0
//   - (EX.Dst == ID_Rs) or (ID_UsesRt and EX.Dst == ID_Rt)
//   - Flush is 0
//  Flush overrides Stall: Stall = 0 and the bubble is still inserted.
//  A single load-use dependency stalls exactly 1 cycle. The next cycle EX holds a bubble, so Stall drops.
//  ForwardA (combinational from shadows), priority order:
//   - MEM.RegWrite and !MEM.MemRead and MEM.Dst != 0 and MEM.Dst == EX.Rs -> 01
//   - else WB.RegWrite and WB.Dst != 0 and WB.Dst == EX.Rs -> 10
//   - else 00
//  ForwardB: same rule using EX.Rt.
//  Newest producer wins: MEM beats WB when both match.
//  Writes to $zero are never forwarded and never cause a stall.
//  StallCount:
//   - increments by 1 on each Clk edge where Stall = 1
//   - holds at 2^CNT_W-1 (no wrap)
//  Reset values: ForwardA = ForwardB = 00, Stall = 0, StallCount = 0.
//  Reset asserted mid-operation clears all shadows immediately (async).
//  After release, the first instruction sees no forwarding and no stall.
//  Latency: selects and Stall are valid in the same cycle as their inputs; there are no registered outputs.
// TESTING
//  1. add $3 in ID, then sub using $3 as rs next cycle
//     -> ForwardA=01 when sub is in EX; one cycle later, an instr using $3 gets ForwardA=10.
//  2. lw $4 then add $5,$4,$4 back to back
//     -> Stall=1 for exactly 1 cycle, StallCount 0->1;
//        then ForwardA=ForwardB=10 when add is in EX.
//  3. lw $0 followed by a use of $0, and add $0 followed by a use of $0
//     -> Stall=0, ForwardA/B=00 throughout.
//  4. Flush=1 in the same cycle a load-use hazard is detected
//     -> Stall=0, bubble in EX;
//        the following cycle ForwardA/B=00 and StallCount is unchanged.
//  5. Same reg (e.g. $7) written in MEM and WB, read in EX -> select 01 (MEM priority).
//     sw with rt matching EX-stage lw (ID_UsesRt=1) -> Stall=1.
//  6. Rst_n pulsed low mid-stream with a load in EX
//     -> Stall, ForwardA/B, StallCount go to 0 before the next edge.
//     Also: force Stall for 2^CNT_W+3 cycles (CNT_W=4 build) -> StallCount saturates at 15.

Source files
------------

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage MIPS pipeline.
// Shadows EX/MEM/WB destination info and drives ALU operand mux selects plus the IF/ID stall.
module fwd_hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic [REG_W-1:0] ex_dst;
  logic             ex_reg_write;
  logic             ex_mem_read;

  logic [REG_W-1:0] mem_dst;
  logic             mem_reg_write;
  logic             mem_mem_read;

  logic [REG_W-1:0] wb_dst;
  logic             wb_reg_write;

  logic             bubble;
  logic             ex_load_live;
  logic             rs_dep;
  logic             rt_dep;
  logic             mem_fwd_ok;
  logic             wb_fwd_ok;

  // A load still in EX has no data yet; only the MEM/WB copies can be forwarded.
  assign ex_load_live = ex_mem_read && (ex_dst != '0);
  assign rs_dep       = (ex_dst == id_rs);
  assign rt_dep       = id_uses_rt && (ex_dst == id_rt);

  always_comb begin
    stall = 1'b0;
    if (ex_load_live && (rs_dep || rt_dep) && !flush) begin
      stall = 1'b1;
    end
  end

  assign bubble = stall || flush;

  assign mem_fwd_ok = mem_reg_write && !mem_mem_read && (mem_dst != '0);
  assign wb_fwd_ok  = wb_reg_write && (wb_dst != '0);

  // MEM is checked first so the newest producer wins.
  always_comb begin
    forward_a = FWD_RF;
    if (mem_fwd_ok && (mem_dst == ex_rs)) begin
      forward_a = FWD_MEM;
    end else if (wb_fwd_ok && (wb_dst == ex_rs)) begin
      forward_a = FWD_WB;
    end
  end

  always_comb begin
    forward_b = FWD_RF;
    if (mem_fwd_ok && (mem_dst == ex_rt)) begin
      forward_b = FWD_MEM;
    end else if (wb_fwd_ok && (wb_dst == ex_rt)) begin
      forward_b = FWD_WB;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else if (bubble) begin
      ex_rs        <= '0;
      ex_rt        <= '0;
      ex_dst       <= '0;
      ex_reg_write <= 1'b0;
      ex_mem_read  <= 1'b0;
    end else begin
      ex_rs        <= id_rs;
      ex_rt        <= id_rt;
      ex_dst       <= id_dst;
      ex_reg_write <= id_reg_write;
      ex_mem_read  <= id_mem_read;
    end
  end

  // Downstream stages never back-pressure, so MEM and WB always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_dst       <= '0;
      mem_reg_write <= 1'b0;
      mem_mem_read  <= 1'b0;
      wb_dst        <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      mem_dst       <= ex_dst;
      mem_reg_write <= ex_reg_write;
      mem_mem_read  <= ex_mem_read;
      wb_dst        <= mem_dst;
      wb_reg_write  <= mem_reg_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl; a second CNT_W=4 instance
// shares the stimulus so the saturating counter can be exercised quickly.
module tb_fwd_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic [4:0] id_dst;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;

  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        stall;
  logic [15:0] stall_count;

  logic [1:0]  forwardASmall;
  logic [1:0]  forwardBSmall;
  logic        stallSmall;
  logic [3:0]  stallCountSmall;

  typedef struct {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        st;
    logic [15:0] cnt;
    logic [3:0]  cntSmall;
  } exp_t;

  exp_t sbq[$];
  int   total;
  int   bad;
  int   stepNo;

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .forward_a    (forward_a),
    .forward_b    (forward_b),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  fwd_hazard_ctrl #(.REG_W(5), .CNT_W(4)) dutSmall (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_dst       (id_dst),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .forward_a    (forwardASmall),
    .forward_b    (forwardBSmall),
    .stall        (stallSmall),
    .stall_count  (stallCountSmall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s step=%0d got=%0h want=%0h", tag, stepNo, obs, expv);
    end
  endtask

  // Drive the decode-stage instruction and queue what the outputs must show this cycle.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                               input logic [4:0] dst, input logic rw, input logic mr,
                               input logic fl, input logic [1:0] efa, input logic [1:0] efb,
                               input logic est, input int ecnt);
    exp_t e;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = ut;
    id_dst       = dst;
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    e.fa       = efa;
    e.fb       = efb;
    e.st       = est;
    e.cnt      = 16'(ecnt);
    e.cntSmall = (ecnt > 15) ? 4'd15 : 4'(ecnt);
    sbq.push_back(e);
    #1;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_empty step=%0d got=0 want=1", stepNo);
      return;
    end
    e = sbq.pop_front();
    cmp("forward_a", 16'(forward_a), 16'(e.fa));
    cmp("forward_b", 16'(forward_b), 16'(e.fb));
    cmp("stall", 16'(stall), 16'(e.st));
    cmp("stall_count", stall_count, e.cnt);
    cmp("stall_count_w4", 16'(stallCountSmall), 16'(e.cntSmall));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    stepNo++;
  endtask

  task automatic st(input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                    input logic [4:0] dst, input logic rw, input logic mr, input logic fl,
                    input logic [1:0] efa, input logic [1:0] efb, input logic est,
                    input int ecnt);
    applyStimulus(rs, rt, ut, dst, rw, mr, fl, efa, efb, est, ecnt);
    checkOutput();
    tick();
  endtask

  task automatic nop(input int ecnt);
    st(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, ecnt);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    stepNo = 0;
    rst_n  = 1'b0;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_dst = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    // reset state
    applyStimulus(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    checkOutput();
    rst_n = 1'b1;
    tick();

    // add $3 ; sub $6,$3,$5 ; or $7,$3,$9
    st(5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    st(5'd3, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    st(5'd3, 5'd9, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 0);
    st(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 0);
    nop(0); nop(0); nop(0);

    // lw $4 ; add $5,$4,$4 (held one extra cycle by the stall)
    st(5'd1, 5'd4, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    st(5'd4, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 0);
    st(5'd4, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 1);
    nop(1); nop(1); nop(1);

    // $zero never forwards or stalls
    st(5'd1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd0, 5'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd1, 5'd1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    nop(1); nop(1); nop(1); nop(1);

    // flush on a load-use cycle: no stall, bubble, count unchanged
    st(5'd1, 5'd4, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd4, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1);
    st(5'd5, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    nop(1); nop(1); nop(1);

    // $7 written in MEM and WB, read in EX: MEM wins
    st(5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd3, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd7, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1);
    nop(1);
    // lw $9 ; sw $9,0($2) stalls through rt
    st(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1);
    st(5'd2, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1);
    st(5'd2, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2);
    st(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 2);
    // lw $10 then an instruction not reading rt: no stall, no forward from load in MEM
    st(5'd1, 5'd10, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2);
    st(5'd2, 5'd10, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2);
    nop(2); nop(2); nop(2); nop(2);

    // add $4 ; lw $6,0($4) ; add $7,$6,$6 then async reset with the load in EX
    st(5'd1, 5'd2, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2);
    st(5'd4, 5'd6, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2);
    applyStimulus(5'd6, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 2);
    checkOutput();
    rst_n = 1'b0;
    applyStimulus(5'd6, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    checkOutput();
    rst_n = 1'b1;
    tick();
    st(5'd6, 5'd4, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 0);
    nop(0); nop(0); nop(0); nop(0);

    // lw $4,0($4) held in decode: stalls every other cycle, 19 stalls total
    for (int i = 0; i < 38; i++) begin
      logic [1:0] f;
      f = ((i % 2 == 1) && (i >= 3)) ? 2'b10 : 2'b00;
      st(5'd4, 5'd4, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, f, f, 1'(i % 2), i / 2);
    end
    nop(19);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
